cache_control: RTL and testbench
================================

# cache_control

Sequencing FSM for the 2-way, write-back, write-allocate L1 cache. It sits between the CPU-side memory port and the cacheline adaptor. It drives per-byte write masks into both ways' data arrays, plus load/set/clear strobes for the tag, valid, dirty and LRU arrays in the cache datapath. Hits complete combinationally in the request's cycle; misses run an optional writeback followed by a line fill, then replay as a hit.

## Interface
Parameters:
- s_offset, 5, log2 bytes per line; minimum 2
- s_index, 3, log2 sets; passed through for mask and width consistency only

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- mem_byte_enable  in  4  byte enables of the 32-bit CPU word
- mem_word_offset  in  s_offset-2  word position within the line (address bits [s_offset-1:2])
- hit  in  2  per-way tag match AND valid, from datapath
- dirty  in  2  per-way dirty bit of the indexed set
- lru  in  1  way to evict for the indexed set
- mem_resp  out  1  CPU request complete
- data_we0, data_we1  out  2**s_offset  byte write masks for way 0 / way 1 data arrays
- datain_sel  out  1  0 = CPU word replicated across line, 1 = pmem line
- way_sel  out  1  way whose line drives pmem write data and CPU read mux
- addr_sel  out  1  0 = CPU address to pmem, 1 = {victim tag, index} writeback address
- tag_load, valid_set, dirty_set, dirty_clr  out  2 each  per-way array strobes
- lru_load  out  1  write lru_in to LRU array
- lru_in  out  1  new LRU value (way NOT just used)
- pmem_read, pmem_write  out  1  cacheline adaptor requests; held until pmem_resp
- pmem_resp  in  1  cacheline adaptor done (one-cycle pulse)

## Operation
States: CHECK, WRITEBACK, FILL. Reset state CHECK.
- CHECK with no request: all outputs 0.
- Read hit on way w:
  - mem_resp=1, way_sel=w.
  - lru_load=1, lru_in=~w.
- Write hit on way w:
  - Same as read hit, plus datain_sel=0.
  - data_we_w[4*mem_word_offset +: 4]=mem_byte_enable; all other mask bits 0.
  - dirty_set[w]=1.
- Miss (hit==0, request present):
  - Victim v=lru.
  - dirty[v]=1 -> WRITEBACK; otherwise -> FILL.
  - No strobes and no mem_resp in the miss cycle.
- WRITEBACK:
  - pmem_write=1, addr_sel=1, way_sel=v.
  - On pmem_resp -> FILL.
- FILL:
  - pmem_read=1, addr_sel=0, datain_sel=1.
  - On pmem_resp, in that same cycle:
    - data_we_v = all ones.
    - tag_load[v], valid_set[v], dirty_clr[v] = 1.
  - Then -> CHECK. The next cycle is a hit and completes as above.
- Victim v is registered on leaving CHECK. It is not re-read from lru during WRITEBACK/FILL.
- hit==2'b11 is illegal. Way 0 wins.
- mem_read and mem_write both high is treated as a write.
- Request dropped before mem_resp is illegal. The FSM finishes the fill anyway and returns to CHECK idle.

## Timing
- Reset: every output 0 in the cycle after rst is sampled high. State returns to CHECK from any state, abandoning a pmem transaction; the adaptor shares rst.
- Hit latency: 0 cycles. mem_resp is combinational in the request's first cycle.
- Clean miss: 1 (CHECK) + N_fill + 1 (replay hit) cycles, where N_fill counts FILL cycles through pmem_resp.
- Dirty miss: adds the WRITEBACK cycles through pmem_resp.
- pmem_read/pmem_write are never asserted together. They deassert the cycle after pmem_resp.
- mem_resp is at most one cycle per request. It is never asserted in WRITEBACK or FILL.

## Configuration
- CACHE_PERF_COUNTERS_EN defined:
  - Adds outputs hit_count and miss_count, 32 bits each, wrapping.
  - hit_count increments on each CHECK cycle with mem_resp=1, excluding the post-fill replay.
  - miss_count increments on each CHECK-to-WRITEBACK/FILL transition.
  - Both clear on rst.
- Not defined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, state CHECK; no pmem activity for 10 idle cycles.
- Read hit: hit=2'b10, mem_read=1 -> same-cycle mem_resp=1, way_sel=1, lru_load=1, lru_in=0, data masks 0.
- Write hit: hit=2'b01, mem_word_offset=3, mem_byte_enable=4'b0110 -> data_we0=32'h0000_6000, dirty_set=2'b01, mem_resp=1.
- Clean miss: hit=0, lru=1, dirty=2'b00, pmem_resp after 4 cycles -> FILL; on resp data_we1=32'hFFFF_FFFF, tag_load/valid_set/dirty_clr=2'b10; hit next cycle -> mem_resp.
- Dirty miss: lru=0, dirty=2'b01 -> pmem_write with addr_sel=1 until resp, then pmem_read; never both high; mem_resp only after the fill.
- Reset mid-FILL: assert rst while pmem_read=1 -> pmem_read=0 next cycle; no tag_load; CHECK idle; with CACHE_PERF_COUNTERS_EN, counters read 0.

Source files
------------

// File: rtl/cache_control.sv
// Sequencing FSM for the 2-way write-back, write-allocate L1 cache: hits finish in-cycle, misses write back then fill.
// Optional hit/miss counters are compiled in with `define CACHE_PERF_COUNTERS_EN.
`timescale 1ns/1ps
module cache_control #(
   parameter int s_offset = 5,
   parameter int s_index  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mem_read,
   input  logic                    mem_write,
   input  logic [3:0]              mem_byte_enable,
   input  logic [s_offset-3:0]     mem_word_offset,
   input  logic [1:0]              hit,
   input  logic [1:0]              dirty,
   input  logic                    lru,
   output logic                    mem_resp,
   output logic [2**s_offset-1:0]  data_we0,
   output logic [2**s_offset-1:0]  data_we1,
   output logic                    datain_sel,
   output logic                    way_sel,
   output logic                    addr_sel,
   output logic [1:0]              tag_load,
   output logic [1:0]              valid_set,
   output logic [1:0]              dirty_set,
   output logic [1:0]              dirty_clr,
   output logic                    lru_load,
   output logic                    lru_in,
   output logic                    pmem_read,
   output logic                    pmem_write,
`ifdef CACHE_PERF_COUNTERS_EN
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count,
`endif
   input  logic                    pmem_resp
);

   localparam int LINE_B = 2**s_offset;

   if (s_offset < 2 || s_index < 0) begin : g_cfg_check
      $error("cache_control: s_offset must be >= 2 and s_index >= 0");
   end

   typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_t;

   state_t             state;
   logic               victim;
   logic               replay;
   logic               req;
   logic               hit_way;
   logic [LINE_B-1:0]  word_mask;

   assign req       = mem_read | mem_write;
   // hit==2'b11 is illegal; way 0 takes priority
   assign hit_way   = ~hit[0];
   assign word_mask = {{(LINE_B-4){1'b0}}, mem_byte_enable} << {mem_word_offset, 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= CHECK;
         replay <= 1'b0;
      end else begin
         replay <= (state == FILL) && pmem_resp;
         case (state)
            CHECK:     if (req && (hit == 2'b00)) state <= dirty[lru] ? WRITEBACK : FILL;
            WRITEBACK: if (pmem_resp) state <= FILL;
            FILL:      if (pmem_resp) state <= CHECK;
            default:   state <= CHECK;
         endcase
      end
   end

   // Victim is frozen when leaving CHECK so lru changes mid-miss are ignored
   always_ff @(posedge clk) begin
      if (state == CHECK && req && (hit == 2'b00)) victim <= lru;
   end

`ifdef CACHE_PERF_COUNTERS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= 32'd0;
         miss_count <= 32'd0;
      end else if (state == CHECK) begin
         if (mem_resp && !replay) hit_count <= hit_count + 32'd1;
         if (req && (hit == 2'b00)) miss_count <= miss_count + 32'd1;
      end
   end
`endif

   always_comb begin
      mem_resp   = 1'b0;
      data_we0   = '0;
      data_we1   = '0;
      datain_sel = 1'b0;
      way_sel    = 1'b0;
      addr_sel   = 1'b0;
      tag_load   = 2'b00;
      valid_set  = 2'b00;
      dirty_set  = 2'b00;
      dirty_clr  = 2'b00;
      lru_load   = 1'b0;
      lru_in     = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      case (state)
         CHECK: begin
            if (req && (hit != 2'b00)) begin
               mem_resp = 1'b1;
               way_sel  = hit_way;
               lru_load = 1'b1;
               lru_in   = ~hit_way;
               if (mem_write) begin
                  dirty_set[hit_way] = 1'b1;
                  if (hit_way) data_we1 = word_mask;
                  else         data_we0 = word_mask;
               end
            end
         end
         WRITEBACK: begin
            pmem_write = 1'b1;
            addr_sel   = 1'b1;
            way_sel    = victim;
         end
         FILL: begin
            pmem_read  = 1'b1;
            datain_sel = 1'b1;
            if (pmem_resp) begin
               tag_load[victim]  = 1'b1;
               valid_set[victim] = 1'b1;
               dirty_clr[victim] = 1'b1;
               if (victim) data_we1 = '1;
               else        data_we0 = '1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: stimulus pushes hand-computed expected outputs, a monitor pops and compares.
`timescale 1ns/1ps
module tb_cache_control;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [3:0]  mem_byte_enable;
   logic [2:0]  mem_word_offset;
   logic [1:0]  hit, dirty;
   logic        lru, pmem_resp;
   logic        mem_resp, datain_sel, way_sel, addr_sel, lru_load, lru_in, pmem_read, pmem_write;
   logic [31:0] data_we0, data_we1;
   logic [1:0]  tag_load, valid_set, dirty_set, dirty_clr;
   logic [31:0] hit_count, miss_count;

   cache_control #(.s_offset(5), .s_index(3)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_word_offset(mem_word_offset),
      .hit(hit), .dirty(dirty), .lru(lru), .mem_resp(mem_resp),
      .data_we0(data_we0), .data_we1(data_we1), .datain_sel(datain_sel),
      .way_sel(way_sel), .addr_sel(addr_sel), .tag_load(tag_load),
      .valid_set(valid_set), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
      .lru_load(lru_load), .lru_in(lru_in), .pmem_read(pmem_read),
      .pmem_write(pmem_write),
`ifdef CACHE_PERF_COUNTERS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .pmem_resp(pmem_resp)
   );

`ifndef CACHE_PERF_COUNTERS_EN
   assign hit_count  = 32'd0;
   assign miss_count = 32'd0;
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic        mem_resp;
      logic [31:0] we0;
      logic [31:0] we1;
      logic        datain_sel, way_sel, addr_sel;
      logic [1:0]  tag_load, valid_set, dirty_set, dirty_clr;
      logic        lru_load, lru_in, pmem_read, pmem_write;
   } outv_t;

   typedef struct {
      string       name;
      outv_t       v;
      logic [31:0] hc;
      logic [31:0] mc;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_hits = 0;
   logic [31:0] m_miss = 0;

   function automatic outv_t o_hit(input logic w, input logic [31:0] m, input logic wr);
      outv_t o = '0;
      o.mem_resp = 1'b1;
      o.way_sel  = w;
      o.lru_load = 1'b1;
      o.lru_in   = ~w;
      if (wr) begin
         o.dirty_set[w] = 1'b1;
         if (w) o.we1 = m;
         else   o.we0 = m;
      end
      return o;
   endfunction

   function automatic outv_t o_wb(input logic v);
      outv_t o = '0;
      o.pmem_write = 1'b1;
      o.addr_sel   = 1'b1;
      o.way_sel    = v;
      return o;
   endfunction

   function automatic outv_t o_fill(input logic v, input logic done);
      outv_t o = '0;
      o.pmem_read  = 1'b1;
      o.datain_sel = 1'b1;
      if (done) begin
         o.tag_load[v]  = 1'b1;
         o.valid_set[v] = 1'b1;
         o.dirty_clr[v] = 1'b1;
         if (v) o.we1 = 32'hFFFF_FFFF;
         else   o.we0 = 32'hFFFF_FFFF;
      end
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [3:0] be, input logic [2:0] off,
                        input logic [1:0] h, input logic [1:0] d, input logic l, input logic pr);
      mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_word_offset = off;
      hit = h; dirty = d; lru = l; pmem_resp = pr;
   endtask

   task automatic chk(input string nm, input outv_t e, input bit hevt, input bit mevt);
      exp_t x;
      x.name = nm; x.v = e; x.hc = m_hits; x.mc = m_miss;
      q.push_back(x);
      if (rst) begin
         m_hits = 0;
         m_miss = 0;
      end else begin
         if (hevt) m_hits = m_hits + 1;
         if (mevt) m_miss = m_miss + 1;
      end
   endtask

   // Monitor: compares the DUT against each queued expectation mid-cycle
   initial begin
      exp_t  x;
      outv_t a;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x = q.pop_front();
            a = {mem_resp, data_we0, data_we1, datain_sel, way_sel, addr_sel,
                 tag_load, valid_set, dirty_set, dirty_clr, lru_load, lru_in, pmem_read, pmem_write};
            checks++;
            if (a !== x.v) begin
               errors++;
               $display("FAIL %s: outputs got %h expected %h", x.name, a, x.v);
            end
`ifdef CACHE_PERF_COUNTERS_EN
            checks++;
            if (hit_count !== x.hc || miss_count !== x.mc) begin
               errors++;
               $display("FAIL %s_counters: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                        x.name, hit_count, miss_count, x.hc, x.mc);
            end
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      repeat (2) begin tick(); chk("reset", '0, 0, 0); end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin tick(); chk("idle", '0, 0, 0); end

      // Hits
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0); chk("rd_hit_w1", o_hit(1'b1, 32'h0, 1'b0), 1, 0);
      tick(); drive(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("idle_after_hit", '0, 0, 0);
      tick(); drive(0, 1, 4'b0110, 3'd3, 2'b01, 2'b00, 1'b0, 1'b0); chk("wr_hit_w0", o_hit(1'b0, 32'h0000_6000, 1'b1), 1, 0);
      tick(); drive(0, 1, 4'b1111, 3'd7, 2'b10, 2'b00, 1'b0, 1'b0); chk("wr_hit_w1_top", o_hit(1'b1, 32'hF000_0000, 1'b1), 1, 0);
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b11, 2'b00, 1'b0, 1'b0); chk("hit_both_w0", o_hit(1'b0, 32'h0, 1'b0), 1, 0);
      tick(); drive(1, 1, 4'b0001, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0); chk("rd_wr_as_wr", o_hit(1'b1, 32'h0000_0001, 1'b1), 1, 0);
      tick(); drive(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("idle", '0, 0, 0);

      // Clean miss, victim way 1; lru flips during fill and must be ignored
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0); chk("clean_miss", '0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("fill_wait_w1", o_fill(1'b1, 1'b0), 0, 0);
      end
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1); chk("fill_done_w1", o_fill(1'b1, 1'b1), 0, 0);
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0); chk("replay_w1", o_hit(1'b1, 32'h0, 1'b0), 0, 0);
      tick(); drive(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("idle", '0, 0, 0);

      // Dirty write miss, victim way 0
      tick(); drive(0, 1, 4'hF, 3'd2, 2'b00, 2'b01, 1'b0, 1'b0); chk("dirty_miss_w0", '0, 0, 1);
      tick(); drive(0, 1, 4'hF, 3'd2, 2'b00, 2'b00, 1'b1, 1'b0); chk("wb_wait_w0", o_wb(1'b0), 0, 0);
      tick(); drive(0, 1, 4'hF, 3'd2, 2'b00, 2'b00, 1'b1, 1'b1); chk("wb_done_w0", o_wb(1'b0), 0, 0);
      tick(); drive(0, 1, 4'hF, 3'd2, 2'b00, 2'b00, 1'b1, 1'b0); chk("fill_after_wb", o_fill(1'b0, 1'b0), 0, 0);
      tick(); drive(0, 1, 4'hF, 3'd2, 2'b00, 2'b00, 1'b1, 1'b1); chk("fill_done_w0", o_fill(1'b0, 1'b1), 0, 0);
      tick(); drive(0, 1, 4'hF, 3'd2, 2'b01, 2'b00, 1'b1, 1'b0); chk("replay_wr_w0", o_hit(1'b0, 32'h0000_0F00, 1'b1), 0, 0);
      tick(); drive(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("idle", '0, 0, 0);

      // Dirty read miss, victim way 1, single-cycle adaptor responses
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b10, 1'b1, 1'b0); chk("dirty_miss_w1", '0, 0, 1);
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b10, 1'b1, 1'b1); chk("wb_done_w1", o_wb(1'b1), 0, 0);
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b10, 1'b1, 1'b1); chk("fill_done_w1b", o_fill(1'b1, 1'b1), 0, 0);
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b10, 2'b00, 1'b0, 1'b0); chk("replay_w1b", o_hit(1'b1, 32'h0, 1'b0), 0, 0);
      tick(); drive(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("idle", '0, 0, 0);

      // Only the non-victim way is dirty: no writeback
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b01, 1'b1, 1'b0); chk("nonvictim_dirty", '0, 0, 1);
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b01, 1'b1, 1'b1); chk("fill_nv", o_fill(1'b1, 1'b1), 0, 0);
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b10, 2'b01, 1'b1, 1'b0); chk("replay_nv", o_hit(1'b1, 32'h0, 1'b0), 0, 0);
      tick(); drive(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("idle", '0, 0, 0);

      // Reset while filling
      tick(); drive(1, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("rst_miss", '0, 0, 1);
      tick(); chk("rst_fill", o_fill(1'b0, 1'b0), 0, 0);
      tick(); rst = 1'b1; chk("rst_fill_asserted", o_fill(1'b0, 1'b0), 0, 0);
      tick(); rst = 1'b0; drive(0, 0, 4'h0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0); chk("after_rst", '0, 0, 0);
      for (int i = 0; i < 3; i++) begin tick(); chk("idle_after_rst", '0, 0, 0); end

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: pending expectations got %0d expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
